// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// Pipeline stage 4 (memory). Sits directly after the execute stage and consumes
// its result / destination / opcode.
//   * ALU ops (add/sub/mul) are forwarded to writeback one cycle later.
//   * LDB/LDW/STB/STW run a req/ack transaction on the data-memory port. The
//     stage stalls upstream until the ack arrives, then emits a writeback
//     pulse one cycle after the ack.
//   * nop / unknown opcodes / ex_valid=0 produce a writeback bubble.
//
// Configuration macro: MEM_BYPASS_EN
//   defined   -> fwd_reg/fwd_data are registered copies of wb_dst/wb_data
//                whenever wb_we=1 (fwd_reg=0 otherwise), same timing as wb_*.
//   undefined -> fwd_reg/fwd_data are tied to zero.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   ex_valid/op/dst/result/sdata  execute-stage outputs
//   mem_stall                  combinational hold request to upstream stages
//   dmem_req/we/addr/be/wdata  data-memory request (held stable until ack)
//   dmem_rdata/ack             data-memory response (1-cycle ack pulse)
//   wb_valid/we/dst/data       writeback slot (single-cycle pulses)
//   fwd_reg/fwd_data           bypass path (see MEM_BYPASS_EN)
// -----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int ADDR_W = 20,
    parameter int OP_W   = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [OP_W-1:0]   ex_op,
    input  logic [4:0]        ex_dst,
    input  logic [31:0]       ex_result,
    input  logic [31:0]       ex_sdata,
    output logic              mem_stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [4:0]        wb_dst,
    output logic [31:0]       wb_data,
    output logic [4:0]        fwd_reg,
    output logic [31:0]       fwd_data
);

    localparam logic [OP_W-1:0] OP_ADD = OP_W'(8'h00);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(8'h01);
    localparam logic [OP_W-1:0] OP_MUL = OP_W'(8'h02);
    localparam logic [OP_W-1:0] OP_LDB = OP_W'(8'h10);
    localparam logic [OP_W-1:0] OP_LDW = OP_W'(8'h11);
    localparam logic [OP_W-1:0] OP_STB = OP_W'(8'h12);
    localparam logic [OP_W-1:0] OP_STW = OP_W'(8'h13);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t              state_q, state_d;
    logic                dmem_req_q, dmem_req_d;
    logic                dmem_we_q, dmem_we_d;
    logic [ADDR_W-1:0]   dmem_addr_q, dmem_addr_d;
    logic [3:0]          dmem_be_q, dmem_be_d;
    logic [31:0]         dmem_wdata_q, dmem_wdata_d;
    logic [4:0]          dst_q, dst_d;
    logic                is_load_q, is_load_d;
    logic                is_byte_q, is_byte_d;
    logic [1:0]          lane_q, lane_d;
    logic                wb_valid_q, wb_valid_d;
    logic                wb_we_q, wb_we_d;
    logic [4:0]          wb_dst_q, wb_dst_d;
    logic [31:0]         wb_data_q, wb_data_d;

    logic                op_is_alu, op_is_mem, op_is_store, op_is_byte;
    logic [7:0]          rd_byte;
    logic [31:0]         load_data;

    assign op_is_alu   = (ex_op == OP_ADD) || (ex_op == OP_SUB) || (ex_op == OP_MUL);
    assign op_is_mem   = (ex_op == OP_LDB) || (ex_op == OP_LDW) ||
                         (ex_op == OP_STB) || (ex_op == OP_STW);
    assign op_is_store = (ex_op == OP_STB) || (ex_op == OP_STW);
    assign op_is_byte  = (ex_op == OP_LDB) || (ex_op == OP_STB);

    // Byte lane select for LDB; lane 0 is the least significant byte.
    always_comb begin
        case (lane_q)
            2'd0:    rd_byte = dmem_rdata[7:0];
            2'd1:    rd_byte = dmem_rdata[15:8];
            2'd2:    rd_byte = dmem_rdata[23:16];
            default: rd_byte = dmem_rdata[31:24];
        endcase
    end

    assign load_data = is_byte_q ? {24'd0, rd_byte} : dmem_rdata;

    always_comb begin
        state_d      = state_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_be_d    = dmem_be_q;
        dmem_wdata_d = dmem_wdata_q;
        dst_d        = dst_q;
        is_load_d    = is_load_q;
        is_byte_d    = is_byte_q;
        lane_d       = lane_q;
        wb_valid_d   = 1'b0;
        wb_we_d      = 1'b0;
        wb_dst_d     = wb_dst_q;
        wb_data_d    = wb_data_q;
        mem_stall    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ex_valid && op_is_alu) begin
                    wb_valid_d = 1'b1;
                    wb_we_d    = (ex_dst != 5'd0);
                    wb_dst_d   = ex_dst;
                    wb_data_d  = ex_result;
                end else if (ex_valid && op_is_mem) begin
                    mem_stall    = 1'b1;
                    state_d      = S_WAIT;
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = op_is_store;
                    dmem_addr_d  = ex_result[ADDR_W+1:2];
                    dst_d        = ex_dst;
                    is_load_d    = !op_is_store;
                    is_byte_d    = op_is_byte;
                    lane_d       = ex_result[1:0];
                    // Word ops ignore the low address bits entirely.
                    dmem_be_d    = op_is_byte ? 4'(4'b0001 << ex_result[1:0]) : 4'b1111;
                    if (ex_op == OP_STB) begin
                        dmem_wdata_d = {4{ex_sdata[7:0]}};
                    end else if (ex_op == OP_STW) begin
                        dmem_wdata_d = ex_sdata;
                    end else begin
                        dmem_wdata_d = 32'd0;
                    end
                end
            end
            S_WAIT: begin
                // Upstream is held, so ex_* is not looked at here.
                mem_stall = !dmem_ack;
                if (dmem_ack) begin
                    state_d    = S_IDLE;
                    dmem_req_d = 1'b0;
                    dmem_we_d  = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_dst_d   = dst_q;
                    if (is_load_q) begin
                        wb_data_d = load_data;
                        wb_we_d   = (dst_q != 5'd0);
                    end else begin
                        wb_data_d = 32'd0;
                        wb_we_d   = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_be_q    <= 4'd0;
            dmem_wdata_q <= 32'd0;
            dst_q        <= 5'd0;
            is_load_q    <= 1'b0;
            is_byte_q    <= 1'b0;
            lane_q       <= 2'd0;
            wb_valid_q   <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_dst_q     <= 5'd0;
            wb_data_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_be_q    <= dmem_be_d;
            dmem_wdata_q <= dmem_wdata_d;
            dst_q        <= dst_d;
            is_load_q    <= is_load_d;
            is_byte_q    <= is_byte_d;
            lane_q       <= lane_d;
            wb_valid_q   <= wb_valid_d;
            wb_we_q      <= wb_we_d;
            wb_dst_q     <= wb_dst_d;
            wb_data_q    <= wb_data_d;
        end
    end

`ifdef MEM_BYPASS_EN
    logic [4:0]  fwd_reg_q, fwd_reg_d;
    logic [31:0] fwd_data_q, fwd_data_d;

    // r0 is never a live source, so 0 means "nothing to forward".
    always_comb begin
        fwd_reg_d  = wb_we_d ? wb_dst_d  : 5'd0;
        fwd_data_d = wb_we_d ? wb_data_d : 32'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_reg_q  <= 5'd0;
            fwd_data_q <= 32'd0;
        end else begin
            fwd_reg_q  <= fwd_reg_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    assign fwd_reg  = fwd_reg_q;
    assign fwd_data = fwd_data_q;
`else
    assign fwd_reg  = 5'd0;
    assign fwd_data = 32'd0;
`endif

    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_be    = dmem_be_q;
    assign dmem_wdata = dmem_wdata_q;
    assign wb_valid   = wb_valid_q;
    assign wb_we      = wb_we_q;
    assign wb_dst     = wb_dst_q;
    assign wb_data    = wb_data_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
//
// Directed bench for mem_access_stage: ALU pass-through, word/byte loads and
// stores with a hand-driven req/ack memory, back-to-back memory ops, bubbles,
// spurious ack, r0 destination, bypass outputs and reset during a transaction.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

    localparam int ADDR_W = 20;
    localparam int OP_W   = 7;

`ifdef MEM_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ex_valid;
    logic [OP_W-1:0]   ex_op;
    logic [4:0]        ex_dst;
    logic [31:0]       ex_result;
    logic [31:0]       ex_sdata;
    logic              mem_stall;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [3:0]        dmem_be;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata;
    logic              dmem_ack;
    logic              wb_valid;
    logic              wb_we;
    logic [4:0]        wb_dst;
    logic [31:0]       wb_data;
    logic [4:0]        fwd_reg;
    logic [31:0]       fwd_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.ADDR_W(ADDR_W), .OP_W(OP_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .ex_op      (ex_op),
        .ex_dst     (ex_dst),
        .ex_result  (ex_result),
        .ex_sdata   (ex_sdata),
        .mem_stall  (mem_stall),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .wb_valid   (wb_valid),
        .wb_we      (wb_we),
        .wb_dst     (wb_dst),
        .wb_data    (wb_data),
        .fwd_reg    (fwd_reg),
        .fwd_data   (fwd_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive a memory op from the current (IDLE) cycle, check the issue-cycle
    // stall, then step to the first WAIT cycle.
    task automatic issue(input logic [6:0] op, input logic [4:0] dst,
                         input logic [31:0] res, input logic [31:0] sd);
        ex_valid  = 1'b1;
        ex_op     = op;
        ex_dst    = dst;
        ex_result = res;
        ex_sdata  = sd;
        #1;
        chk("stall_issue", 32'(mem_stall), 32'd1);
        @(posedge clk); #1;
    endtask

    // Hold WAIT for `waits` ack-less cycles, then ack with `rd`. Total stall
    // cycles (including the issue cycle) are compared with exp_stall.
    task automatic serve(input int waits, input logic [31:0] rd, input int exp_stall);
        int stall_cnt;
        stall_cnt = 1;
        for (int i = 0; i < waits; i++) begin
            if (mem_stall) stall_cnt++;
            @(posedge clk); #1;
        end
        dmem_ack   = 1'b1;
        dmem_rdata = rd;
        #1;
        chk("stall_on_ack", 32'(mem_stall), 32'd0);
        chk("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
        @(posedge clk); #1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
    endtask

    initial begin
        rst_n      = 1'b0;
        ex_valid   = 1'b0;
        ex_op      = 7'h3F;
        ex_dst     = 5'd0;
        ex_result  = 32'd0;
        ex_sdata   = 32'd0;
        dmem_rdata = 32'd0;
        dmem_ack   = 1'b0;

        // Reset state
        #12;
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_dmem_we", 32'(dmem_we), 32'd0);
        chk("rst_dmem_addr", 32'(dmem_addr), 32'd0);
        chk("rst_dmem_be", 32'(dmem_be), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_fwd_reg", 32'(fwd_reg), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ALU add -> writeback after one cycle, no stall
        ex_valid = 1'b1; ex_op = 7'h00; ex_dst = 5'd5; ex_result = 32'h12345678;
        #1;
        chk("add_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        chk("add_wb_valid", 32'(wb_valid), 32'd1);
        chk("add_wb_we", 32'(wb_we), 32'd1);
        chk("add_wb_dst", 32'(wb_dst), 32'd5);
        chk("add_wb_data", wb_data, 32'h12345678);
        chk("add_fwd_reg", 32'(fwd_reg), BYP ? 32'd5 : 32'd0);
        chk("add_fwd_data", fwd_data, BYP ? 32'h12345678 : 32'd0);
        $display("txn add dst=5 wb_data=0x%08h", wb_data);
        @(posedge clk); #1;
        chk("add_pulse_valid", 32'(wb_valid), 32'd0);
        chk("add_pulse_we", 32'(wb_we), 32'd0);

        // Bubbles: nop, unknown op, ALU op with ex_valid=0
        ex_valid = 1'b1; ex_op = 7'h3F; ex_dst = 5'd3;
        #1; chk("nop_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        chk("nop_wb_valid", 32'(wb_valid), 32'd0);
        ex_op = 7'h05;
        #1; chk("unk_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        chk("unk_wb_valid", 32'(wb_valid), 32'd0);
        chk("unk_dmem_req", 32'(dmem_req), 32'd0);
        ex_valid = 1'b0; ex_op = 7'h01;
        @(posedge clk); #1;
        chk("inv_wb_valid", 32'(wb_valid), 32'd0);
        $display("txn bubbles nop/unknown/invalid");

        // Spurious ack in IDLE
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
        chk("spur_wb_valid", 32'(wb_valid), 32'd0);
        chk("spur_dmem_req", 32'(dmem_req), 32'd0);
        $display("txn spurious ack");

        // LDW 0x10, ack after 3 wait cycles
        issue(7'h11, 5'd3, 32'h00000010, 32'd0);
        chk("ldw_req", 32'(dmem_req), 32'd1);
        chk("ldw_we", 32'(dmem_we), 32'd0);
        chk("ldw_addr", 32'(dmem_addr), 32'd4);
        chk("ldw_be", 32'(dmem_be), 32'hF);
        chk("ldw_wait_wb", 32'(wb_valid), 32'd0);
        serve(3, 32'hDEADBEEF, 4);
        ex_valid = 1'b0;
        chk("ldw_req_drop", 32'(dmem_req), 32'd0);
        chk("ldw_wb_valid", 32'(wb_valid), 32'd1);
        chk("ldw_wb_we", 32'(wb_we), 32'd1);
        chk("ldw_wb_dst", 32'(wb_dst), 32'd3);
        chk("ldw_wb_data", wb_data, 32'hDEADBEEF);
        $display("txn LDW addr=0x10 wb_data=0x%08h", wb_data);
        @(posedge clk); #1;
        chk("ldw_pulse", 32'(wb_valid), 32'd0);

        // LDB 0x0A -> lane 2
        issue(7'h10, 5'd4, 32'h0000000A, 32'd0);
        chk("ldb_addr", 32'(dmem_addr), 32'd2);
        chk("ldb_be", 32'(dmem_be), 32'h4);
        serve(1, 32'hAABBCCDD, 2);
        ex_valid = 1'b0;
        chk("ldb_wb_valid", 32'(wb_valid), 32'd1);
        chk("ldb_wb_data", wb_data, 32'h000000BB);
        $display("txn LDB addr=0x0A wb_data=0x%08h", wb_data);
        @(posedge clk); #1;

        // STB 0x07 -> lane 3, replicated data; ack on first WAIT cycle
        issue(7'h12, 5'd9, 32'h00000007, 32'h0000005A);
        chk("stb_we", 32'(dmem_we), 32'd1);
        chk("stb_addr", 32'(dmem_addr), 32'd1);
        chk("stb_be", 32'(dmem_be), 32'h8);
        chk("stb_wdata", dmem_wdata, 32'h5A5A5A5A);
        serve(0, 32'h0, 1);
        chk("stb_wb_valid", 32'(wb_valid), 32'd1);
        chk("stb_wb_we", 32'(wb_we), 32'd0);
        chk("stb_wb_data", wb_data, 32'd0);
        chk("stb_fwd_reg", 32'(fwd_reg), 32'd0);
        $display("txn STB addr=0x07 wdata=0x5A5A5A5A");

        // Back-to-back: STW accepted in the IDLE cycle right after the ack
        issue(7'h13, 5'd2, 32'h00000023, 32'h11223344);
        chk("stw_req", 32'(dmem_req), 32'd1);
        chk("stw_addr", 32'(dmem_addr), 32'd8);
        chk("stw_be", 32'(dmem_be), 32'hF);
        chk("stw_wdata", dmem_wdata, 32'h11223344);
        serve(2, 32'h0, 3);
        chk("stw_wb_valid", 32'(wb_valid), 32'd1);
        chk("stw_wb_we", 32'(wb_we), 32'd0);
        $display("txn STW addr=0x23 wdata=0x11223344");

        // LDW to r0: writeback slot valid but no register write
        issue(7'h11, 5'd0, 32'h00000040, 32'd0);
        serve(1, 32'hCAFEF00D, 2);
        chk("r0_wb_valid", 32'(wb_valid), 32'd1);
        chk("r0_wb_we", 32'(wb_we), 32'd0);
        chk("r0_fwd_reg", 32'(fwd_reg), 32'd0);
        $display("txn LDW dst=r0");

        // LDW dst=7 data=1 -> bypass outputs
        issue(7'h11, 5'd7, 32'h00000100, 32'd0);
        serve(0, 32'h00000001, 1);
        ex_valid = 1'b0;
        chk("byp_wb_data", wb_data, 32'd1);
        chk("byp_fwd_reg", 32'(fwd_reg), BYP ? 32'd7 : 32'd0);
        chk("byp_fwd_data", fwd_data, BYP ? 32'd1 : 32'd0);
        $display("txn LDW dst=7 fwd_reg=%0d fwd_data=0x%08h", fwd_reg, fwd_data);
        @(posedge clk); #1;
        chk("byp_fwd_clear", 32'(fwd_reg), 32'd0);

        // Reset during WAIT: request drops at once, no writeback afterwards
        issue(7'h11, 5'd6, 32'h00000080, 32'd0);
        chk("rstw_req_pre", 32'(dmem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstw_req_drop", 32'(dmem_req), 32'd0);
        ex_valid   = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h55555555;
        @(negedge clk);
        rst_n = 1'b1;
        dmem_ack = 1'b0;
        @(posedge clk); #1;
        chk("rstw_wb_valid", 32'(wb_valid), 32'd0);
        chk("rstw_req_idle", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        chk("rstw_wb_valid2", 32'(wb_valid), 32'd0);
        $display("txn reset during WAIT");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
